// File: rtl/midi_parser.sv
// -----------------------------------------------------------------------------
// midi_parser
//   Turns the MIDI byte stream coming from the UART receiver into complete
//   channel-voice messages for the voice engine. Running status is tracked.
//   SysEx and system-common data bytes are discarded. Real-time bytes
//   (0xF8-0xFF) are reported on their own one-cycle strobe and leave message
//   assembly untouched.
//
// Parameters
//   OMNI     1: emit messages on every channel, 0: emit only CHANNEL
//   CHANNEL  channel number used when OMNI = 0
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   s_data      received MIDI byte
//   s_valid     s_data valid
//   s_ready     byte accepted when s_valid && s_ready (= !m_valid)
//   m_status    status byte of the emitted message
//   m_data1     first data byte
//   m_data2     second data byte (0 for one-data-byte commands)
//   m_valid     message valid, held until taken with m_ready
//   m_ready     consumer accepts the message
//   rt_valid    one-cycle strobe: a real-time byte was received
//   rt_byte     most recent real-time byte
//   sync_error  one-cycle strobe: a data byte was dropped (no running status)
//
// Configuration macro
//   MIDI_VEL0_NOTEOFF_EN  when defined, note-on with velocity 0 is emitted as
//                         note-off (0x8n, data2 = 0)
// -----------------------------------------------------------------------------
module midi_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_status,
    output logic [6:0] m_data1,
    output logic [6:0] m_data2,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       sync_error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_D1 = 3'd1,
        ST_WAIT_D2 = 3'd2,
        ST_SKIP    = 3'd3,
        ST_SYSEX   = 3'd4
    } state_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_data(input logic [7:0] status);
        return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_run_status;
    logic [7:0] w_run_status_nxt;
    logic [6:0] r_d1;
    logic [6:0] w_d1_nxt;
    logic [1:0] r_skip_cnt;
    logic [1:0] w_skip_cnt_nxt;
    logic [7:0] r_m_status;
    logic [7:0] w_m_status_nxt;
    logic [6:0] r_m_data1;
    logic [6:0] w_m_data1_nxt;
    logic [6:0] r_m_data2;
    logic [6:0] w_m_data2_nxt;
    logic       r_m_valid;
    logic       w_m_valid_nxt;
    logic       r_rt_valid;
    logic       w_rt_valid_nxt;
    logic [7:0] r_rt_byte;
    logic [7:0] w_rt_byte_nxt;
    logic       r_sync_error;
    logic       w_sync_error_nxt;

    logic       w_accept;
    logic       w_emit;
    logic [6:0] w_emit_d1;
    logic [6:0] w_emit_d2;
    logic [7:0] w_emit_status;
    logic       w_chan_ok;

    // A pending message stalls every input byte, real-time bytes included.
    assign s_ready  = ~r_m_valid;
    assign w_accept = s_valid & ~r_m_valid;

    assign m_status   = r_m_status;
    assign m_data1    = r_m_data1;
    assign m_data2    = r_m_data2;
    assign m_valid    = r_m_valid;
    assign rt_valid   = r_rt_valid;
    assign rt_byte    = r_rt_byte;
    assign sync_error = r_sync_error;

    // Next-state and next-output decode for each accepted byte.
    always_comb begin
        w_state_nxt      = r_state;
        w_run_status_nxt = r_run_status;
        w_d1_nxt         = r_d1;
        w_skip_cnt_nxt   = r_skip_cnt;
        w_m_status_nxt   = r_m_status;
        w_m_data1_nxt    = r_m_data1;
        w_m_data2_nxt    = r_m_data2;
        w_rt_valid_nxt   = 1'b0;
        w_rt_byte_nxt    = r_rt_byte;
        w_sync_error_nxt = 1'b0;
        w_emit           = 1'b0;
        w_emit_d1        = r_d1;
        w_emit_d2        = 7'd0;
        w_emit_status    = r_run_status;
        w_chan_ok        = 1'b0;

        if (r_m_valid && m_ready) begin
            w_m_valid_nxt = 1'b0;
        end else begin
            w_m_valid_nxt = r_m_valid;
        end

        if (w_accept) begin
            if (s_data[7]) begin
                if (s_data[7:3] == 5'b11111) begin
                    // Real-time: only the strobe and the latched byte change.
                    w_rt_valid_nxt = 1'b1;
                    w_rt_byte_nxt  = s_data;
                end else if (s_data[7:4] != 4'hF) begin
                    // Channel status: new running status, abandon partial data.
                    w_run_status_nxt = s_data;
                    w_d1_nxt         = 7'd0;
                    w_skip_cnt_nxt   = 2'd0;
                    w_state_nxt      = ST_WAIT_D1;
                end else begin
                    // System common / SysEx delimiters drop running status.
                    w_run_status_nxt = 8'h00;
                    w_d1_nxt         = 7'd0;
                    case (s_data[2:0])
                        3'd0: begin
                            w_state_nxt    = ST_SYSEX;
                            w_skip_cnt_nxt = 2'd0;
                        end
                        3'd1, 3'd3: begin
                            w_state_nxt    = ST_SKIP;
                            w_skip_cnt_nxt = 2'd1;
                        end
                        3'd2: begin
                            w_state_nxt    = ST_SKIP;
                            w_skip_cnt_nxt = 2'd2;
                        end
                        default: begin
                            w_state_nxt    = ST_IDLE;
                            w_skip_cnt_nxt = 2'd0;
                        end
                    endcase
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_sync_error_nxt = 1'b1;
                    end
                    ST_WAIT_D1: begin
                        w_d1_nxt = s_data[6:0];
                        if (is_one_data(r_run_status)) begin
                            w_emit    = 1'b1;
                            w_emit_d1 = s_data[6:0];
                            w_emit_d2 = 7'd0;
                        end else begin
                            w_state_nxt = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_emit      = 1'b1;
                        w_emit_d1   = r_d1;
                        w_emit_d2   = s_data[6:0];
                        w_state_nxt = ST_WAIT_D1;
                    end
                    ST_SKIP: begin
                        if (r_skip_cnt <= 2'd1) begin
                            w_skip_cnt_nxt = 2'd0;
                            w_state_nxt    = ST_IDLE;
                        end else begin
                            w_skip_cnt_nxt = r_skip_cnt - 2'd1;
                        end
                    end
                    ST_SYSEX: begin
                        w_state_nxt = ST_SYSEX;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end

`ifdef MIDI_VEL0_NOTEOFF_EN
        if ((r_run_status[7:4] == 4'h9) && (w_emit_d2 == 7'd0)) begin
            w_emit_status = {4'h8, r_run_status[3:0]};
        end else begin
            w_emit_status = r_run_status;
        end
`else
        w_emit_status = r_run_status;
`endif

        // Filtered messages still complete internally; they just never show.
        w_chan_ok = OMNI || (r_run_status[3:0] == CHANNEL);

        if (w_emit && w_chan_ok) begin
            w_m_valid_nxt  = 1'b1;
            w_m_status_nxt = w_emit_status;
            w_m_data1_nxt  = w_emit_d1;
            w_m_data2_nxt  = w_emit_d2;
        end else begin
            w_m_status_nxt = r_m_status;
        end
    end

    // Parser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Running status, partial data and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_status <= 8'h00;
            r_d1         <= 7'd0;
            r_skip_cnt   <= 2'd0;
            r_m_status   <= 8'h00;
            r_m_data1    <= 7'd0;
            r_m_data2    <= 7'd0;
            r_m_valid    <= 1'b0;
            r_rt_valid   <= 1'b0;
            r_rt_byte    <= 8'h00;
            r_sync_error <= 1'b0;
        end else begin
            r_run_status <= w_run_status_nxt;
            r_d1         <= w_d1_nxt;
            r_skip_cnt   <= w_skip_cnt_nxt;
            r_m_status   <= w_m_status_nxt;
            r_m_data1    <= w_m_data1_nxt;
            r_m_data2    <= w_m_data2_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_rt_valid   <= w_rt_valid_nxt;
            r_rt_byte    <= w_rt_byte_nxt;
            r_sync_error <= w_sync_error_nxt;
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// -----------------------------------------------------------------------------
// tb_midi_parser
//   Directed-vector bench for midi_parser. Two instances: an OMNI parser
//   (sel = 0) and a channel-3-only parser (sel = 1). Inputs are driven 1 ns
//   after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_parser;

    logic       clk;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       m_ready;
    logic       sel;

    logic       s_valid_0, s_valid_1;
    logic       s_ready_0, s_ready_1;
    logic [7:0] m_status_0, m_status_1;
    logic [6:0] m_data1_0, m_data1_1;
    logic [6:0] m_data2_0, m_data2_1;
    logic       m_valid_0, m_valid_1;
    logic       rt_valid_0, rt_valid_1;
    logic [7:0] rt_byte_0, rt_byte_1;
    logic       sync_error_0, sync_error_1;

    logic       o_s_ready;
    logic [7:0] o_m_status;
    logic [6:0] o_m_data1;
    logic [6:0] o_m_data2;
    logic       o_m_valid;
    logic       o_rt_valid;
    logic [7:0] o_rt_byte;
    logic       o_sync_error;

    int n_cmp;
    int n_err;

    assign s_valid_0 = s_valid & ~sel;
    assign s_valid_1 = s_valid & sel;

    assign o_s_ready    = sel ? s_ready_1    : s_ready_0;
    assign o_m_status   = sel ? m_status_1   : m_status_0;
    assign o_m_data1    = sel ? m_data1_1    : m_data1_0;
    assign o_m_data2    = sel ? m_data2_1    : m_data2_0;
    assign o_m_valid    = sel ? m_valid_1    : m_valid_0;
    assign o_rt_valid   = sel ? rt_valid_1   : rt_valid_0;
    assign o_rt_byte    = sel ? rt_byte_1    : rt_byte_0;
    assign o_sync_error = sel ? sync_error_1 : sync_error_0;

    midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_dut_omni (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_0),
        .s_ready(s_ready_0), .m_status(m_status_0), .m_data1(m_data1_0),
        .m_data2(m_data2_0), .m_valid(m_valid_0), .m_ready(m_ready),
        .rt_valid(rt_valid_0), .rt_byte(rt_byte_0), .sync_error(sync_error_0)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd3)) u_dut_ch3 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_1),
        .s_ready(s_ready_1), .m_status(m_status_1), .m_data1(m_data1_1),
        .m_data2(m_data2_1), .m_valid(m_valid_1), .m_ready(m_ready),
        .rt_valid(rt_valid_1), .rt_byte(rt_byte_1), .sync_error(sync_error_1)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and wait (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!o_s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk_val("s_ready_timeout", 32'(o_s_ready), 32'd1);
        end
        s_data  = b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_msg(input string tag, input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
        chk_val({tag, "_valid"},  32'(o_m_valid),  32'd1);
        chk_val({tag, "_status"}, 32'(o_m_status), 32'(st));
        chk_val({tag, "_d1"},     32'(o_m_data1),  32'(d1));
        chk_val({tag, "_d2"},     32'(o_m_data2),  32'(d2));
        chk_val({tag, "_sready"}, 32'(o_s_ready),  32'd0);
    endtask

    // Take the pending message and check the handshake releases.
    task automatic take_msg(input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk_val({tag, "_taken_valid"},  32'(o_m_valid), 32'd0);
        chk_val({tag, "_taken_sready"}, 32'(o_s_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk_val("rst_m_valid", 32'(o_m_valid), 32'd0);
        chk_val("rst_s_ready", 32'(o_s_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b0;
        sel     = 1'b0;
        #2;
        // Reset state.
        chk_val("rst_m_status",   32'(o_m_status),   32'h00);
        chk_val("rst_m_data1",    32'(o_m_data1),    32'h00);
        chk_val("rst_m_data2",    32'(o_m_data2),    32'h00);
        chk_val("rst_m_valid",    32'(o_m_valid),    32'd0);
        chk_val("rst_rt_valid",   32'(o_rt_valid),   32'd0);
        chk_val("rst_rt_byte",    32'(o_rt_byte),    32'h00);
        chk_val("rst_sync_error", 32'(o_sync_error), 32'd0);
        chk_val("rst_s_ready",    32'(o_s_ready),    32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Note-on, then running status.
        send_byte(8'h90);
        chk_val("no1_early_a", 32'(o_m_valid), 32'd0);
        send_byte(8'h3C);
        chk_val("no1_early_b", 32'(o_m_valid), 32'd0);
        send_byte(8'h64);
        chk_msg("no1", 8'h90, 7'h3C, 7'h64);
        take_msg("no1");
        send_byte(8'h3E);
        chk_val("rs_early", 32'(o_m_valid), 32'd0);
        send_byte(8'h50);
        chk_msg("rs", 8'h90, 7'h3E, 7'h50);
        take_msg("rs");

        // Program change with consumer always ready.
        m_ready = 1'b1;
        send_byte(8'hC2);
        send_byte(8'h05);
        chk_msg("pc1", 8'hC2, 7'h05, 7'h00);
        send_byte(8'h07);
        chk_msg("pc2", 8'hC2, 7'h07, 7'h00);
        tick();
        chk_val("pc_drained", 32'(o_m_valid), 32'd0);
        m_ready = 1'b0;

        // Real-time byte in the middle of a message.
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        chk_val("rt_valid",    32'(o_rt_valid), 32'd1);
        chk_val("rt_byte",     32'(o_rt_byte),  32'hF8);
        chk_val("rt_no_msg",   32'(o_m_valid),  32'd0);
        tick();
        chk_val("rt_one_cyc",  32'(o_rt_valid), 32'd0);
        chk_val("rt_byte_hold", 32'(o_rt_byte), 32'hF8);
        send_byte(8'h64);
        chk_msg("rt_msg", 8'h90, 7'h3C, 7'h64);
        take_msg("rt_msg");

        // Data bytes with no running status.
        pulse_reset();
        send_byte(8'h3C);
        chk_val("se1", 32'(o_sync_error), 32'd1);
        tick();
        chk_val("se1_one_cyc", 32'(o_sync_error), 32'd0);
        send_byte(8'h64);
        chk_val("se2", 32'(o_sync_error), 32'd1);
        chk_val("se2_no_msg", 32'(o_m_valid), 32'd0);

        // SysEx body is silently discarded; after F7 there is no running status.
        send_byte(8'hF0);
        send_byte(8'h01);
        chk_val("sx_d1_quiet", 32'(o_sync_error), 32'd0);
        send_byte(8'h02);
        chk_val("sx_d2_quiet", 32'(o_sync_error), 32'd0);
        send_byte(8'hF7);
        send_byte(8'h3C);
        chk_val("sx_after_se", 32'(o_sync_error), 32'd1);
        chk_val("sx_no_msg",   32'(o_m_valid),    32'd0);

        // Song position: two skipped data bytes, then back to idle.
        send_byte(8'hF2);
        send_byte(8'h01);
        send_byte(8'h02);
        chk_val("skip_quiet", 32'(o_sync_error), 32'd0);
        send_byte(8'h03);
        chk_val("skip_done_se", 32'(o_sync_error), 32'd1);

        // Status mid-message abandons the partial message.
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h80);
        send_byte(8'h40);
        chk_val("abandon_early", 32'(o_m_valid), 32'd0);
        send_byte(8'h7F);
        chk_msg("abandon", 8'h80, 7'h40, 7'h7F);
        take_msg("abandon");

        // Velocity-0 note-on.
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h00);
`ifdef MIDI_VEL0_NOTEOFF_EN
        chk_msg("vel0", 8'h80, 7'h3C, 7'h00);
`else
        chk_msg("vel0", 8'h90, 7'h3C, 7'h00);
`endif
        take_msg("vel0");

        // Reset while a message is pending.
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        chk_val("prerst_valid", 32'(o_m_valid), 32'd1);
        pulse_reset();
        chk_val("postrst_valid", 32'(o_m_valid), 32'd0);
        send_byte(8'h3C);
        chk_val("postrst_se", 32'(o_sync_error), 32'd1);

        // Channel filter instance.
        sel = 1'b1;
        #1;
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        chk_val("filt_ch1", 32'(o_m_valid), 32'd0);
        send_byte(8'h93);
        send_byte(8'h3C);
        send_byte(8'h64);
        chk_msg("filt_ch3", 8'h93, 7'h3C, 7'h64);
        // Back-pressure: the next byte waits while the message is held.
        s_data  = 8'h3E;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_msg("hold", 8'h93, 7'h3C, 7'h64);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk_val("hold_rel_valid",  32'(o_m_valid), 32'd0);
        chk_val("hold_rel_sready", 32'(o_s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        send_byte(8'h40);
        chk_msg("hold_next", 8'h93, 7'h3E, 7'h40);
        take_msg("hold_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
